// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: rising-edge capture into pending bits, round-robin issue over valid/ready
module edge_event_arbiter #(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_CH-1:0]  sig_i,
  output logic             ev_valid_o,
  output logic [IDX_W-1:0] ev_idx_o,
  input  logic             ev_ready_i,
  output logic [N_CH-1:0]  pend_o,
  output logic [N_CH-1:0]  ovf_o,
  input  logic             ovf_clr_i
);
  typedef enum logic {IDLE, OFFER} state_e;
  state_e           state_q, state_d;
  logic [N_CH-1:0]  sig_q, pend_q, pend_d, ovf_q, ovf_d, edge_v, hs_vec;
  logic             valid_q, valid_d, hs;
  logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d, sel;
  assign edge_v     = sig_i & ~sig_q;
  assign hs         = valid_q & ev_ready_i;
  assign hs_vec     = hs ? (N_CH'(1) << idx_q) : '0;
  assign ev_valid_o = valid_q;
  assign ev_idx_o   = idx_q;
  assign pend_o     = pend_q;
  assign ovf_o      = ovf_q;
  // pending bits: a coincident edge re-arms a channel being retired; merged edges go sticky
  always_comb begin
    pend_d = (pend_q & ~hs_vec) | edge_v;
    ovf_d  = (ovf_clr_i ? '0 : ovf_q) | (edge_v & pend_q & ~hs_vec);
  end
  // round-robin pick over registered pend: lowest offset after last grant wins
  always_comb begin
    logic [IDX_W:0] c;
    sel = '0;
    c   = '0;
    for (int k = N_CH; k >= 1; k--) begin
      c = {1'b0, last_q} + (IDX_W+1)'(k);
      c = (c >= (IDX_W+1)'(N_CH)) ? c - (IDX_W+1)'(N_CH) : c;
      if (pend_q[c[IDX_W-1:0]]) sel = c[IDX_W-1:0];
    end
  end
  // offer FSM: load a grant in IDLE, hold it in OFFER until accepted
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (state_q == IDLE) begin
      if (|pend_q) begin
        idx_d   = sel;
        valid_d = 1'b1;
        state_d = OFFER;
      end
    end else if (ev_ready_i) begin
      valid_d = 1'b0;
      last_d  = idx_q;
      state_d = IDLE;
    end
  end
  // state registers; last grant starts at the top channel so channel 0 leads
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sig_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= IDX_W'(N_CH-1);
    end else begin
      state_q <= state_d;
      sig_q   <= sig_i;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed vectors with hand-computed expectations
module tb_edge_event_arbiter;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] sig_i = '0;
  logic       ev_ready_i = 1'b0;
  logic       ovf_clr_i = 1'b0;
  logic       ev_valid_o;
  logic [1:0] ev_idx_o;
  logic [3:0] pend_o, ovf_o;
  int         n_vec = 0;
  int         n_err = 0;
  edge_event_arbiter #(.N_CH(4), .IDX_W(2)) dut (
    .clk(clk), .resetn(resetn), .sig_i(sig_i),
    .ev_valid_o(ev_valid_o), .ev_idx_o(ev_idx_o), .ev_ready_i(ev_ready_i),
    .pend_o(pend_o), .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    sig_i = '0;
    ev_ready_i = 1'b0;
    ovf_clr_i = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [1:0] i, input logic [3:0] p);
    check({tag, ".valid"}, 32'(ev_valid_o), 32'(v));
    if (v) check({tag, ".idx"}, 32'(ev_idx_o), 32'(i));
    check({tag, ".pend"}, 32'(pend_o), 32'(p));
  endtask
  initial begin
    int seen;
    do_reset();
    chk_out("rst", 1'b0, 2'd0, 4'b0000);
    check("rst.idx", 32'(ev_idx_o), 0);
    check("rst.ovf", 32'(ovf_o), 0);
    // single edge, ready high
    ev_ready_i = 1'b1;
    sig_i = 4'b0100;
    tick(); chk_out("t1.c1", 1'b0, 2'd0, 4'b0100);
    tick(); chk_out("t1.c2", 1'b1, 2'd2, 4'b0100);
    tick(); chk_out("t1.c3", 1'b0, 2'd0, 4'b0000);
    check("t1.ovf", 32'(ovf_o), 0);
    // three simultaneous edges from reset priority
    do_reset();
    ev_ready_i = 1'b1;
    sig_i = 4'b1011;
    tick(); chk_out("t2.c1", 1'b0, 2'd0, 4'b1011);
    tick(); chk_out("t2.c2", 1'b1, 2'd0, 4'b1011);
    tick(); chk_out("t2.c3", 1'b0, 2'd0, 4'b1010);
    tick(); chk_out("t2.c4", 1'b1, 2'd1, 4'b1010);
    tick(); chk_out("t2.c5", 1'b0, 2'd0, 4'b1000);
    tick(); chk_out("t2.c6", 1'b1, 2'd3, 4'b1000);
    tick(); chk_out("t2.c7", 1'b0, 2'd0, 4'b0000);
    // fairness after grant to 3
    sig_i = 4'b0000;
    tick();
    sig_i = 4'b1001;
    tick(); chk_out("t3a.c1", 1'b0, 2'd0, 4'b1001);
    tick(); chk_out("t3a.c2", 1'b1, 2'd0, 4'b1001);
    tick(); chk_out("t3a.c3", 1'b0, 2'd0, 4'b1000);
    tick(); chk_out("t3a.c4", 1'b1, 2'd3, 4'b1000);
    tick(); chk_out("t3a.c5", 1'b0, 2'd0, 4'b0000);
    // fairness after grant to 1
    sig_i = 4'b0010;
    tick(); tick(); chk_out("t3b.g1", 1'b1, 2'd1, 4'b0010);
    tick(); chk_out("t3b.g1d", 1'b0, 2'd0, 4'b0000);
    sig_i = 4'b0101;
    tick(); chk_out("t3b.c1", 1'b0, 2'd0, 4'b0101);
    tick(); chk_out("t3b.c2", 1'b1, 2'd2, 4'b0101);
    tick(); chk_out("t3b.c3", 1'b0, 2'd0, 4'b0001);
    tick(); chk_out("t3b.c4", 1'b1, 2'd0, 4'b0001);
    tick(); chk_out("t3b.c5", 1'b0, 2'd0, 4'b0000);
    // backpressure, overflow and clear priority
    do_reset();
    sig_i = 4'b0010;
    tick(); tick(); chk_out("t4.offer", 1'b1, 2'd1, 4'b0010);
    for (int k = 0; k < 6; k++) begin
      if (k == 1) sig_i = 4'b0000;
      if (k == 3) sig_i = 4'b0010;
      tick(); chk_out("t4.stall", 1'b1, 2'd1, 4'b0010);
    end
    check("t4.ovf", 32'(ovf_o), 32'h2);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    check("t4.clr", 32'(ovf_o), 0);
    sig_i = 4'b0000;
    tick();
    sig_i = 4'b0010;
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    check("t4.setwins", 32'(ovf_o), 32'h2);
    ev_ready_i = 1'b1;
    tick(); chk_out("t4.rel", 1'b0, 2'd0, 4'b0000);
    // edge coincident with own handshake
    do_reset();
    sig_i = 4'b0100;
    tick(); tick(); chk_out("t5.offer", 1'b1, 2'd2, 4'b0100);
    sig_i = 4'b0000;
    tick();
    sig_i = 4'b0100;
    ev_ready_i = 1'b1;
    tick(); chk_out("t5.hs", 1'b0, 2'd0, 4'b0100);
    check("t5.ovf", 32'(ovf_o), 0);
    tick(); chk_out("t5.re", 1'b1, 2'd2, 4'b0100);
    tick(); chk_out("t5.done", 1'b0, 2'd0, 4'b0000);
    // reset during offer with input held high
    do_reset();
    sig_i = 4'b1000;
    tick(); tick(); chk_out("t6.offer", 1'b1, 2'd3, 4'b1000);
    sig_i = 4'b0000;
    tick();
    sig_i = 4'b1000;
    tick();
    check("t6.ovf", 32'(ovf_o), 32'h8);
    resetn = 1'b0;
    #1;
    chk_out("t6.rst", 1'b0, 2'd0, 4'b0000);
    check("t6.rst.ovf", 32'(ovf_o), 0);
    tick();
    resetn = 1'b1;
    ev_ready_i = 1'b1;
    tick(); chk_out("t6.c1", 1'b0, 2'd0, 4'b1000);
    tick(); chk_out("t6.c2", 1'b1, 2'd3, 4'b1000);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ev_valid_o) seen++;
    end
    check("t6.once", 32'(seen), 0);
    check("t6.pend", 32'(pend_o), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
